// File: rtl/ahb_div_slv.sv
// ============================================================================
// Module   : ahb_div_slv
// Brief    : AHB-Lite responder with a register-mapped radix-2 restoring divider
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_div_slv #(
    parameter int DATA_W = 32
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic        hwrite,
    input  logic        hready,
    input  logic [2:0]  hsize,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    input  logic [31:0] haddr,
    output logic        hready_resp,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);

    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;
    localparam logic [1:0] c_ST_DZ   = 2'd3;

    localparam logic [2:0] c_IDX_CTRL  = 3'd0;
    localparam logic [2:0] c_IDX_DVDND = 3'd1;
    localparam logic [2:0] c_IDX_DVSR  = 3'd2;
    localparam logic [2:0] c_IDX_QUOT  = 3'd3;
    localparam logic [2:0] c_IDX_REM   = 3'd4;
    localparam logic [2:0] c_IDX_STAT  = 3'd5;

    localparam logic [1:0] c_RESP_OKAY  = 2'b00;
    localparam logic [1:0] c_RESP_ERROR = 2'b01;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_dvdnd;
    logic [DATA_W-1:0] r_dvsr;
    logic [DATA_W-1:0] r_quot;
    logic [DATA_W-1:0] r_rem;
    logic              r_done;
    logic              r_dz;

    logic              r_wr_pend;
    logic [2:0]        r_wr_idx;
    logic              r_err1;
    logic              r_err2;
    logic              r_stall;
    logic              r_stall_rem;
    logic [31:0]       r_hrdata;

    logic              w_busy;
    logic              w_acc;
    logic [2:0]        w_idx;
    logic              w_mapped;
    logic              w_start;
    logic              w_bad;
    logic              w_err;
    logic              w_ok;
    logic [DATA_W:0]   w_acc_sh;
    logic              w_ge;
    logic [DATA_W-1:0] w_acc_sub;
    logic [DATA_W-1:0] w_acc_nx;
    logic [DATA_W-1:0] w_q_nx;
    logic              w_fin;
    logic [DATA_W-1:0] w_fin_quot;
    logic [DATA_W-1:0] w_fin_rem;
    logic              w_rd_stall;
    logic [31:0]       w_rd_data;

    wire w_unused = ^{hburst, haddr[31:8], htrans[0]};

    generate
        if (DATA_W < 32) begin : g_hwdata_unused
            wire w_unused_hw = ^hwdata[31:DATA_W];
        end
    endgenerate

    assign w_busy   = (r_state == c_ST_RUN) || (r_state == c_ST_DZ);
    assign w_acc    = hsel & hready & htrans[1];
    assign w_idx    = haddr[4:2];
    assign w_mapped = (haddr[7:5] == 3'b000) && (w_idx <= c_IDX_STAT);
    assign w_start  = r_wr_pend && (r_wr_idx == c_IDX_CTRL) && hwdata[0];

    // A start completing this edge counts as busy so a pipelined write cannot slip in.
    assign w_bad = (haddr[1:0] != 2'b00) || (hsize != 3'b010) || !w_mapped
                || (hwrite && (w_idx >= c_IDX_QUOT))
                || (hwrite && (w_busy || w_start));
    assign w_err = w_acc & w_bad;
    assign w_ok  = w_acc & ~w_bad;

    assign w_acc_sh   = {r_acc, r_q[DATA_W-1]};
    assign w_ge       = (w_acc_sh >= {1'b0, r_dvsr});
    assign w_acc_sub  = w_acc_sh[DATA_W-1:0] - r_dvsr;
    assign w_acc_nx   = w_ge ? w_acc_sub : w_acc_sh[DATA_W-1:0];
    assign w_q_nx     = {r_q[DATA_W-2:0], w_ge};
    assign w_fin      = ((r_state == c_ST_RUN) && (r_cnt == '0)) || (r_state == c_ST_DZ);
    assign w_fin_quot = (r_state == c_ST_DZ) ? {DATA_W{1'b1}} : w_q_nx;
    assign w_fin_rem  = (r_state == c_ST_DZ) ? r_q : w_acc_nx;

    assign w_rd_stall = w_busy && !w_fin && ((w_idx == c_IDX_QUOT) || (w_idx == c_IDX_REM));

    always_comb begin
        w_rd_data = 32'd0;
        case (w_idx)
            c_IDX_DVDND: w_rd_data = 32'(r_dvdnd);
            c_IDX_DVSR:  w_rd_data = 32'(r_dvsr);
            c_IDX_QUOT:  w_rd_data = w_fin ? 32'(w_fin_quot) : 32'(r_quot);
            c_IDX_REM:   w_rd_data = w_fin ? 32'(w_fin_rem) : 32'(r_rem);
            c_IDX_STAT:  w_rd_data = {29'd0, r_dz, r_done, w_busy};
            default:     w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_err1      <= 1'b0;
            r_err2      <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_wr_idx    <= 3'd0;
            r_stall     <= 1'b0;
            r_stall_rem <= 1'b0;
            r_hrdata    <= 32'd0;
        end else begin
            r_err1    <= w_err;
            r_err2    <= r_err1;
            r_wr_pend <= w_ok & hwrite;
            if (w_ok) begin
                r_wr_idx <= w_idx;
            end
            if (w_ok && !hwrite) begin
                if (w_rd_stall) begin
                    r_stall     <= 1'b1;
                    r_stall_rem <= (w_idx == c_IDX_REM);
                end else begin
                    r_hrdata <= w_rd_data;
                end
            end else if (r_stall && w_fin) begin
                r_stall  <= 1'b0;
                r_hrdata <= r_stall_rem ? 32'(w_fin_rem) : 32'(w_fin_quot);
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_dvdnd <= '0;
            r_dvsr  <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            if (r_wr_pend && (r_wr_idx == c_IDX_DVDND)) begin
                r_dvdnd <= hwdata[DATA_W-1:0];
            end
            if (r_wr_pend && (r_wr_idx == c_IDX_DVSR)) begin
                r_dvsr <= hwdata[DATA_W-1:0];
            end
            case (r_state)
                c_ST_RUN: begin
                    r_acc <= w_acc_nx;
                    r_q   <= w_q_nx;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_quot  <= w_q_nx;
                        r_rem   <= w_acc_nx;
                        r_done  <= 1'b1;
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DZ: begin
                    r_quot  <= {DATA_W{1'b1}};
                    r_rem   <= r_q;
                    r_dz    <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= c_ST_DONE;
                end
                default: begin
                    // IDLE and DONE both accept a new start.
                    if (w_start) begin
                        r_q     <= r_dvdnd;
                        r_acc   <= '0;
                        r_cnt   <= CNT_W'(DATA_W - 1);
                        r_done  <= 1'b0;
                        r_dz    <= 1'b0;
                        r_state <= (r_dvsr == '0) ? c_ST_DZ : c_ST_RUN;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign hready_resp = ~(r_err1 | r_stall);
    assign hresp       = (r_err1 | r_err2) ? c_RESP_ERROR : c_RESP_OKAY;
    assign hrdata      = r_hrdata;

endmodule

`default_nettype wire

// File: tb/tb_ahb_div_slv.sv
// ============================================================================
// Module   : tb_ahb_div_slv
// Brief    : Randomised self-checking bench for ahb_div_slv against a behavioural model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_div_slv;

    localparam int DATA_W = 32;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic        hwrite;
    logic        hready;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] haddr;
    logic        hready_resp;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    ahb_div_slv #(.DATA_W(DATA_W)) u_dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .hsel        (hsel),
        .hwrite      (hwrite),
        .hready      (hready),
        .hsize       (hsize),
        .htrans      (htrans),
        .hburst      (hburst),
        .hwdata      (hwdata),
        .haddr       (haddr),
        .hready_resp (hready_resp),
        .hresp       (hresp),
        .hrdata      (hrdata)
    );

    always #5 hclk = ~hclk;
    assign hready = hready_resp;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc      = 0;

    // Expected outputs for the current cycle, compared on the falling edge.
    logic        chk_en      = 1'b0;
    logic        exp_rdy     = 1'b1;
    logic [1:0]  exp_resp    = 2'b00;
    logic        exp_rd_chk  = 1'b0;
    logic [31:0] exp_rdata   = 32'd0;
    logic        exp_lit_chk = 1'b0;
    logic [31:0] exp_lit     = 32'd0;

    // Behavioural model: register values plus the edge at which a running division lands.
    logic [31:0] m_dvdnd, m_dvsr, m_quot, m_rem, m_rq, m_rr;
    logic        m_done, m_dz, m_dz_nx, m_run;
    int unsigned m_fin;
    logic        p_busy;
    logic [31:0] p_stat, p_quot, p_rem;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge hclk) begin
        if (chk_en) begin
            check("hready_resp", 32'(hready_resp), 32'(exp_rdy));
            check("hresp", 32'(hresp), 32'(exp_resp));
            if (exp_rd_chk)  check("hrdata_model", hrdata, exp_rdata);
            if (exp_lit_chk) check("hrdata_literal", hrdata, exp_lit);
        end
    end

    task automatic model_reset();
        m_dvdnd = 0; m_dvsr = 0; m_quot = 0; m_rem = 0; m_rq = 0; m_rr = 0;
        m_done = 0; m_dz = 0; m_dz_nx = 0; m_run = 0; m_fin = 0;
        p_busy = 0; p_stat = 0; p_quot = 0; p_rem = 0;
    endtask

    task automatic set_idle_exp();
        exp_rdy = 1'b1; exp_resp = 2'b00; exp_rd_chk = 1'b0; exp_lit_chk = 1'b0;
    endtask

    // Advance one clock; p_* hold the model state seen just before the edge.
    task automatic tick();
        @(posedge hclk);
        cyc++;
        p_busy = m_run;
        p_stat = {29'd0, m_dz, m_done, m_run};
        p_quot = m_quot;
        p_rem  = m_rem;
        if (m_run && cyc == m_fin) begin
            m_quot = m_rq; m_rem = m_rr; m_dz = m_dz_nx; m_done = 1'b1; m_run = 1'b0;
        end
        #1;
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic lit_en, input logic [31:0] lit);
        logic [7:0]  off;
        logic        err;
        logic [31:0] val;
        int unsigned waits;
        off    = addr[7:0];
        hsel   = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
        hburst = 3'($urandom_range(0, 7));
        set_idle_exp();
        tick();
        htrans = 2'b00;
        hwdata = wr ? wdata : $urandom;
        err = (off[1:0] != 2'b00) || (size != 3'b010) || (off > 8'h14)
           || (wr && off >= 8'h0C) || (wr && p_busy);
        if (err) begin
            exp_rdy = 1'b0; exp_resp = 2'b01;
            tick();
            exp_rdy = 1'b1; exp_resp = 2'b01;
            tick();
        end else if (wr) begin
            tick();
            case (off)
                8'h04: m_dvdnd = wdata;
                8'h08: m_dvsr  = wdata;
                default: begin
                    if (wdata[0]) begin
                        m_done = 0; m_dz = 0; m_run = 1;
                        m_fin  = cyc + ((m_dvsr == 0) ? 1 : DATA_W);
                        if (m_dvsr == 0) begin
                            m_rq = 32'hFFFF_FFFF; m_rr = m_dvdnd; m_dz_nx = 1;
                        end else begin
                            m_rq = m_dvdnd / m_dvsr; m_rr = m_dvdnd % m_dvsr; m_dz_nx = 0;
                        end
                    end
                end
            endcase
        end else begin
            case (off)
                8'h04:   val = m_dvdnd;
                8'h08:   val = m_dvsr;
                8'h0C:   val = p_busy ? m_rq : p_quot;
                8'h10:   val = p_busy ? m_rr : p_rem;
                8'h14:   val = p_stat;
                default: val = 32'd0;
            endcase
            waits = (p_busy && (off == 8'h0C || off == 8'h10)) ? (m_fin - cyc) : 0;
            for (int w = 0; w < int'(waits); w++) begin
                exp_rdy = 1'b0; exp_resp = 2'b00;
                tick();
            end
            exp_rdy = 1'b1; exp_resp = 2'b00;
            exp_rd_chk = 1'b1; exp_rdata = val;
            exp_lit_chk = lit_en; exp_lit = lit;
            tick();
        end
        set_idle_exp();
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] d);
        xfer(1'b1, addr, 3'b010, d, 1'b0, 32'd0);
    endtask

    task automatic rd_lit(input logic [31:0] addr, input logic [31:0] lit);
        xfer(1'b0, addr, 3'b010, 32'd0, 1'b1, lit);
    endtask

    task automatic idle(input int n);
        hsel   = 1'($urandom_range(0, 1));
        htrans = 2'($urandom_range(0, 1));
        set_idle_exp();
        for (int k = 0; k < n; k++) tick();
        htrans = 2'b00;
    endtask

    function automatic logic [31:0] rnd_data();
        return ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
    endfunction

    function automatic logic [31:0] rnd_dvsr();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k == 0) return 32'd0;
        if (k < 5)  return 32'($urandom_range(1, 50));
        return $urandom >> $urandom_range(0, 31);
    endfunction

    initial begin
        logic [31:0] up;
        logic [2:0]  sz;
        int unsigned r;
        hsel = 0; hwrite = 0; hsize = 3'b010; htrans = 2'b00; hburst = 3'd0;
        hwdata = 0; haddr = 0;
        model_reset();

        hresetn = 1'b0;
        chk_en = 1'b1;
        exp_rdy = 1'b1; exp_resp = 2'b00;
        exp_rd_chk = 1'b1; exp_rdata = 32'd0; exp_lit_chk = 1'b1; exp_lit = 32'd0;
        repeat (2) @(posedge hclk);
        #1;
        hresetn = 1'b1;
        set_idle_exp();
        rd_lit(32'h14, 32'd0);
        rd_lit(32'h0C, 32'd0);

        // Basic division with status polling.
        wr_reg(32'h04, 32'd100);
        wr_reg(32'h08, 32'd7);
        wr_reg(32'h00, 32'd1);
        for (int k = 0; k < 40 && !m_done; k++) xfer(1'b0, 32'h14, 3'b010, 32'd0, 1'b0, 32'd0);
        rd_lit(32'h0C, 32'd14);
        rd_lit(32'h10, 32'd2);
        rd_lit(32'h14, 32'h2);

        // Stalled quotient read right after start.
        wr_reg(32'h04, 32'hFFFF_FFFF);
        wr_reg(32'h08, 32'd1);
        wr_reg(32'h00, 32'd1);
        rd_lit(32'h0C, 32'hFFFF_FFFF);
        rd_lit(32'h10, 32'd0);

        // Divide by zero.
        wr_reg(32'h08, 32'd0);
        wr_reg(32'h04, 32'h1234);
        wr_reg(32'h00, 32'd1);
        rd_lit(32'h0C, 32'hFFFF_FFFF);
        rd_lit(32'h14, 32'h6);
        rd_lit(32'h10, 32'h1234);

        // Illegal accesses.
        xfer(1'b0, 32'h20, 3'b010, 32'd0, 1'b0, 32'd0);
        xfer(1'b1, 32'h0C, 3'b010, 32'hDEAD, 1'b0, 32'd0);
        xfer(1'b1, 32'h04, 3'b000, 32'hBEEF, 1'b0, 32'd0);
        rd_lit(32'h04, 32'h1234);

        // Write while busy is rejected and does not disturb the running division.
        wr_reg(32'h04, 32'd1000);
        wr_reg(32'h08, 32'd10);
        wr_reg(32'h00, 32'd1);
        wr_reg(32'h04, 32'd5);
        rd_lit(32'h0C, 32'd100);
        rd_lit(32'h04, 32'd1000);

        // Asynchronous reset during a stalled read.
        wr_reg(32'h04, 32'h00AB_CDEF);
        wr_reg(32'h08, 32'd3);
        wr_reg(32'h00, 32'd1);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h0C; hsize = 3'b010;
        tick();
        htrans = 2'b00;
        exp_rdy = 1'b0; exp_resp = 2'b00;
        tick();
        tick();
        #1;
        hresetn = 1'b0;
        hsel = 1'b0;
        model_reset();
        exp_rdy = 1'b1; exp_resp = 2'b00;
        exp_rd_chk = 1'b1; exp_rdata = 32'd0; exp_lit_chk = 1'b1; exp_lit = 32'd0;
        tick();
        hresetn = 1'b1;
        set_idle_exp();
        rd_lit(32'h14, 32'd0);
        rd_lit(32'h0C, 32'd0);
        wr_reg(32'h04, 32'd77);
        wr_reg(32'h08, 32'd5);
        wr_reg(32'h00, 32'd1);
        rd_lit(32'h0C, 32'd15);
        rd_lit(32'h10, 32'd2);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 99);
            up = $urandom & 32'hFFFF_FF00;
            if (r < 15) begin
                wr_reg(up | 32'h04, rnd_data());
            end else if (r < 28) begin
                wr_reg(up | 32'h08, rnd_dvsr());
            end else if (r < 40) begin
                wr_reg(up, ($urandom_range(0, 3) == 0) ? $urandom : 32'd1);
            end else if (r < 75) begin
                xfer(1'b0, up | (4 * $urandom_range(0, 5)), 3'b010, 32'd0, 1'b0, 32'd0);
            end else if (r < 80) begin
                xfer(1'($urandom_range(0, 1)), up | (4 * $urandom_range(6, 63)), 3'b010,
                     $urandom, 1'b0, 32'd0);
            end else if (r < 85) begin
                xfer(1'($urandom_range(0, 1)), up | (4 * $urandom_range(0, 5)) | $urandom_range(1, 3),
                     3'b010, $urandom, 1'b0, 32'd0);
            end else if (r < 90) begin
                sz = 3'($urandom_range(0, 6));
                if (sz >= 3'd2) sz = sz + 3'd1;
                xfer(1'($urandom_range(0, 1)), up | (4 * $urandom_range(0, 5)), sz,
                     $urandom, 1'b0, 32'd0);
            end else if (r < 93) begin
                wr_reg(up | (4 * $urandom_range(3, 5)), $urandom);
            end else begin
                idle(int'($urandom_range(1, 4)));
            end
        end

        idle(2);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
